// File: rtl/gr_bank.sv
// Clocked general-register file: NREAD async read ports, one sync write port,
// per-register busy scoreboard with registered busy count and optional write bypass.
module gr_bank #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREAD*ADDR_W-1:0]   rd_addr,
    output logic [NREAD*DATA_W-1:0]   rd_data,
    output logic [NREAD-1:0]          rd_busy,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rsv_en,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic [ADDR_W:0]           busy_cnt,
    output logic                      any_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              wr_ok;
    logic              rsv_ok;
    logic              same_addr;
    logic              cnt_inc;
    logic              cnt_dec;

    // Writes and reserves aimed at a hardwired zero register are dropped here.
    assign wr_ok     = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign rsv_ok    = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
    assign same_addr = (wr_addr == rsv_addr);

    // Count only real bit transitions; a same-address reserve keeps the bit set.
    assign cnt_inc = rsv_ok && !busy_q[rsv_addr];
    assign cnt_dec = wr_ok && busy_q[wr_addr] && !(rsv_ok && same_addr);
    assign cnt_d   = busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

    // Write clears first so a simultaneous reserve (new producer) wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q   <= '0;
            busy_cnt <= '0;
            any_busy <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            busy_cnt <= cnt_d;
            any_busy <= (cnt_d != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports: zero register overrides bypass, bypass overrides stored state.
    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              zero_hit;
        logic              byp_hit;

        assign a        = rd_addr[g*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (a == '0);
        assign byp_hit  = (BYPASS != 0) && wr_ok && (wr_addr == a);

        assign rd_data[g*DATA_W +: DATA_W] = zero_hit ? '0
                                           : byp_hit  ? wr_data
                                           : regs[a];
        assign rd_busy[g] = zero_hit ? 1'b0
                          : byp_hit  ? (rsv_en && same_addr)
                          : busy_q[a];
    end

endmodule

// File: tb/tb_gr_bank.sv
// Scoreboard bench for gr_bank: driver pushes model expectations, monitor compares
// both a bypassing and a non-bypassing instance at every falling edge.
module tb_gr_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [63:0] rd_data,  rd_data_nb;
    logic [1:0]  rd_busy,  rd_busy_nb;
    logic [5:0]  busy_cnt, busy_cnt_nb;
    logic        any_busy, any_busy_nb;

    always #5 clk = ~clk;

    gr_bank #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy_cnt(busy_cnt), .any_busy(any_busy)
    );

    gr_bank #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_nb), .any_busy(any_busy_nb)
    );

    typedef struct packed {
        logic [63:0] rd;
        logic [1:0]  rb;
        logic [63:0] rd_nb;
        logic [1:0]  rb_nb;
        logic [5:0]  cnt;
        logic        any;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          drv_done = 1'b0;

    // Reference model: architectural register contents and busy flags.
    logic [31:0] mregs [32];
    bit          mbusy [32];

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    // State change at a clock edge: write clears busy, a reserve then sets it.
    task automatic model_edge();
        if (wr_en && wr_addr != 5'd0) begin
            mregs[wr_addr] = wr_data;
            mbusy[wr_addr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 5'd0) mbusy[rsv_addr] = 1'b1;
    endtask

    function automatic exp_t expect_now();
        exp_t        e;
        logic [4:0]  a;
        int          cnt = 0;
        for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? rd_addr[4:0] : rd_addr[9:5];
            if (a == 5'd0) begin
                e.rd[p*32 +: 32]    = '0;
                e.rb[p]             = 1'b0;
                e.rd_nb[p*32 +: 32] = '0;
                e.rb_nb[p]          = 1'b0;
            end else begin
                e.rd_nb[p*32 +: 32] = mregs[a];
                e.rb_nb[p]          = mbusy[a];
                if (wr_en && wr_addr == a) begin
                    e.rd[p*32 +: 32] = wr_data;
                    e.rb[p]          = rsv_en && (rsv_addr == a);
                end else begin
                    e.rd[p*32 +: 32] = mregs[a];
                    e.rb[p]          = mbusy[a];
                end
            end
        end
        for (int i = 0; i < 32; i++) cnt += int'(mbusy[i]);
        e.cnt = 6'(cnt);
        e.any = (cnt != 0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: outputs are combinational/registered state, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data",     rd_data,     e.rd);
                chk("rd_busy",     64'(rd_busy), 64'(e.rb));
                chk("busy_cnt",    64'(busy_cnt), 64'(e.cnt));
                chk("any_busy",    64'(any_busy), 64'(e.any));
                chk("nb_rd_data",  rd_data_nb,  e.rd_nb);
                chk("nb_rd_busy",  64'(rd_busy_nb), 64'(e.rb_nb));
                chk("nb_busy_cnt", 64'(busy_cnt_nb), 64'(e.cnt));
            end
        end
    end

    // One cycle: called just after a rising edge; drives, records expectation, crosses the edge.
    task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit re, input logic [4:0] ra,
                        input logic [4:0] a0, input logic [4:0] a1);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra;
        rd_addr = {a1, a0};
        #1;
        q.push_back(expect_now());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a0, a1);
    endtask

    // Reset pulse between edges; state must clear before any further clock.
    task automatic reset_pulse(input logic [4:0] a0, input logic [4:0] a1);
        wr_en = 1'b0; rsv_en = 1'b0; rd_addr = {a1, a0};
        rst_n = 1'b0;
        model_clear();
        #1;
        q.push_back(expect_now());
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  wa, ra, a0, a1;
        bit          we, re;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < 32; a++) rd(5'(a), 5'(31 - a));

        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
        rd(5'd5, 5'd5);

        step(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0);
        rd(5'd0, 5'd0);

        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd7);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd3, 5'd7);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd7, 5'd9);
        step(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 5'd7, 5'd9);
        rd(5'd7, 5'd3);

        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd9);
        step(1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 5'd4, 5'd3);
        rd(5'd4, 5'd4);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd11, 5'd9, 5'd11);
        rd(5'd9, 5'd11);

        for (int i = 1; i < 32; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(i), 5'd0);
        rd(5'd1, 5'd31);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd5);
        reset_pulse(5'd5, 5'd7);
        rd(5'd5, 5'd4);

        for (int n = 0; n < 600; n++) begin
            we = ($urandom_range(0, 2) != 0);
            re = ($urandom_range(0, 2) != 0);
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : ($urandom_range(0, 2) == 0) ? ra : 5'($urandom);
            if (n % 200 == 199) reset_pulse(a0, a1);
            else step(we, wa, $urandom, re, ra, a0, a1);
        end

        wr_en = 1'b0; rsv_en = 1'b0;
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        drv_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gr_bank.md
Name: gr_bank

Overview:
- Clocked, parametrised general-register file for the multi-cycle CPU datapath; successor to the combinational-write register array.
- Provides NREAD asynchronous read ports and one synchronous write port.
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Per-register busy scoreboard: the control FSM reserves a destination when a multi-cycle op issues, and the write clears the reservation. Decode stalls on busy sources.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and never becomes busy.
- BYPASS, 1, 1 = same-cycle write data/busy-clear is visible on read ports.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rd_addr  input  NREAD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NREAD*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W].
- rd_busy  output  NREAD  1 = register addressed by port i has a pending write.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rsv_en  input  1  reserve strobe: mark rsv_addr busy.
- rsv_addr  input  ADDR_W  register to reserve.
- busy_cnt  output  ADDR_W+1  number of registers currently busy.
- any_busy  output  1  busy_cnt != 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers are 0 and all busy bits are 0.
  - busy_cnt=0, any_busy=0; rd_data reads 0 on every port.
  - Reset asserted mid-operation discards pending reservations immediately, without waiting for a clock.
- Write: on the rising edge with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - With ZERO_REG=1 and wr_addr=0 the write is ignored.
- Reserve: on the rising edge with rsv_en=1, busy[rsv_addr] <= 1.
  - With ZERO_REG=1 and rsv_addr=0 the reserve is ignored.
  - Reserving an already-busy register is legal; the bit stays 1 and busy_cnt is unchanged.
- Simultaneous write and reserve to the same address: data is written and busy ends 1 (the new producer wins); busy_cnt is unchanged if the bit was already 1.
- Simultaneous write and reserve to different addresses: both take effect; busy_cnt is adjusted by +1, -1 or 0 according to the actual bit transitions.
- Write to a non-busy register: legal, busy stays 0.
- busy_cnt: a registered counter updated in the same edge as the busy bits.
  - Always equals the popcount of the busy vector.
  - Maximum value 2**ADDR_W - ZERO_REG; it never wraps.
- Read, combinational, zero latency:
  - rd_data[i] = reg[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]].
  - ZERO_REG=1 and rd_addr[i]=0 gives rd_data 0 and rd_busy 0, regardless of any write.
- Bypass (BYPASS=1), when wr_en=1, wr_addr==rd_addr[i] and the address is not a suppressed zero register:
  - rd_data[i] = wr_data.
  - rd_busy[i] = (rsv_en && rsv_addr==wr_addr).
  - The reserve strobe is not bypassed to other addresses: a reserve is visible on rd_busy only after the edge.
- BYPASS=0: reads reflect only state already clocked in (one-cycle write-to-read latency).
- Multiple read ports addressing the same register return identical values.
- Addresses are always in range (full decode); there are no undefined locations.

Test Plan:
- Reset then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, busy_cnt=0, any_busy=0.
- Write 0xDEADBEEF to r5 with rd_addr0=5 in the same cycle, BYPASS=1 -> rd_data0=0xDEADBEEF before the edge; with BYPASS=0 it shows 0 until after the edge.
- Write 0x12345678 to r0 and reserve r0, ZERO_REG=1 -> rd_data=0, rd_busy=0, busy_cnt=0.
- Reserve r3, r7, r9 on consecutive cycles -> busy_cnt=3; write r7=0x55 -> busy_cnt=2, rd_busy for r7=0, rd_data=0x55.
- Same cycle: write r4=0xAA and reserve r4, with r4 previously busy -> after the edge r4 reads 0xAA, busy=1, busy_cnt unchanged.
- Reserve r1..r31 -> busy_cnt=31; pulse reset low between clock edges -> busy_cnt=0, any_busy=0 immediately, registers 0.
